// File: rtl/stack_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// stack_dmem_responder_if
// Request/response bus between the stack unit (master) and the data-memory
// responder (slave).
//   req_valid    request present (mem_inst | mem_force)
//   req_wr       1 = write (PUSH), 0 = read (POP)
//   req_addr     16-bit byte address, must be word aligned
//   req_wdata    write data
//   req_ready    responder can accept a request this cycle
//   rsp_valid    one-cycle pulse, read data valid
//   rsp_rdata    read data, held until the next rsp_valid
//   wr_ack       one-cycle pulse the cycle after a write is accepted
//   fault        one-cycle pulse with rsp_valid/wr_ack for a bad access
//   fault_sticky set by any fault, cleared only by reset
// ---------------------------------------------------------------------------
interface stack_dmem_responder_if;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        wr_ack;
    logic        fault;
    logic        fault_sticky;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_ack, fault, fault_sticky
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, wr_ack, fault, fault_sticky
    );
endinterface

// File: rtl/stack_dmem_responder.sv
// ---------------------------------------------------------------------------
// stack_dmem_responder
// Word-wide data memory serving the stack unit's PUSH/POP traffic. One
// request per handshake, configurable read latency, a one-entry write buffer
// with read-after-write forwarding, and window/alignment fault reporting.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    stack_dmem_responder_if.slave (request/response signals)
// ---------------------------------------------------------------------------
module stack_dmem_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [15:0] BASE     = 16'hF000,
    parameter int          READ_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    stack_dmem_responder_if.slave   bus
);
    localparam int          IDX_W  = $clog2(DEPTH);
    // 17-bit window bounds so BASE + 2*DEPTH cannot wrap past 16'hFFFF.
    localparam logic [16:0] WIN_LO = {1'b0, BASE};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(2 * DEPTH);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [15:0]       mem [DEPTH];
    logic              wb_valid;
    logic [15:0]       wb_addr;
    logic [15:0]       wb_data;
    logic [15:0]       rd_hold;
    logic              rd_fault_hold;

    logic              accept;
    logic              acc_rd;
    logic              acc_wr;
    logic              bad;
    logic [15:0]       rd_word;

    function automatic logic addr_bad(input logic [15:0] a);
        logic [16:0] a17;
        a17 = {1'b0, a};
        return (a17 < WIN_LO) || (a17 >= WIN_HI) || a[0];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [15:0] a);
        return IDX_W'((a - BASE) >> 1);
    endfunction

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign acc_rd        = accept && !bus.req_wr;
    assign acc_wr        = accept &&  bus.req_wr;
    assign bad           = addr_bad(bus.req_addr);

    // Read data is fixed at acceptance. The buffered write is still pending
    // (it drains on this same edge), so a matching entry must be forwarded.
    always_comb begin
        rd_word = 16'h0000;
        if (!bad) begin
            if (wb_valid && (wb_addr == bus.req_addr)) begin
                rd_word = wb_data;
            end else begin
                rd_word = mem[addr_index(bus.req_addr)];
            end
        end
    end

    // Control path: state, latency counter, response pulses, buffer valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 3'd0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= 16'h0000;
            bus.wr_ack       <= 1'b0;
            bus.fault        <= 1'b0;
            bus.fault_sticky <= 1'b0;
            wb_valid         <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.wr_ack    <= 1'b0;
            bus.fault     <= 1'b0;
            // A faulting write leaves the buffer empty; the old entry still drains.
            wb_valid      <= acc_wr && !bad;
            case (state)
                IDLE: begin
                    if (acc_rd) begin
                        if (READ_LAT == 1) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= rd_word;
                            bus.fault     <= bad;
                            if (bad) bus.fault_sticky <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= 3'(READ_LAT - 1);
                        end
                    end
                    if (acc_wr) begin
                        bus.wr_ack <= 1'b1;
                        bus.fault  <= bad;
                        if (bad) bus.fault_sticky <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rd_hold;
                        bus.fault     <= rd_fault_hold;
                        if (rd_fault_hold) bus.fault_sticky <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: buffer contents, captured read word, array.
    always_ff @(posedge clk) begin
        if (acc_wr && !bad) begin
            wb_addr <= bus.req_addr;
            wb_data <= bus.req_wdata;
        end
        if (acc_rd) begin
            rd_hold       <= rd_word;
            rd_fault_hold <= bad;
        end
        // Reset discards a pending entry before it reaches the array.
        if (wb_valid && !reset) begin
            mem[addr_index(wb_addr)] <= wb_data;
        end
    end
endmodule

// File: doc/stack_dmem_responder.md
Name: stack_dmem_responder

Overview:
- Data-memory responder serving the stack unit's PUSH/POP traffic (and other memory instructions) in dsd_processor.
- Accepts one word request per handshake, with configurable read latency.
- Holds a one-entry write buffer with read-after-write forwarding, so a POP that immediately follows a PUSH returns the pushed value.
- Flags out-of-window and misaligned accesses.

Parameters:
- DEPTH, 256, number of 16-bit words in the array (power of two).
- BASE, 16'hF000, byte address of word 0; the valid window is BASE to BASE+2*DEPTH-1.
- READ_LAT, 2, cycles from read acceptance to rsp_valid (legal range 1..4).

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; requester drives mem_inst|mem_force here.
- req_wr  input  1  1=write (PUSH), 0=read (POP).
- req_addr  input  16  byte address; bit0 must be 0.
- req_wdata  input  16  write data.
- req_ready  output  1  responder can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: read data valid.
- rsp_rdata  output  16  read data; holds its value until the next rsp_valid.
- wr_ack  output  1  one-cycle pulse the cycle after a write is accepted.
- fault  output  1  one-cycle pulse, at rsp_valid/wr_ack timing, for a bad access.
- fault_sticky  output  1  set by any fault; cleared only by reset.

Behaviour:
- Handshake: a request is accepted at a rising edge where req_valid & req_ready. req_ready = (state==IDLE), combinational from state.
- States: IDLE, RD_WAIT.
- Read accepted with READ_LAT==1: rsp_valid is asserted the next cycle and the state stays IDLE. Back-to-back reads run at 1 per cycle.
- Read accepted with READ_LAT>1: go to RD_WAIT with cnt=READ_LAT-1. Decrement cnt each edge. On the edge where cnt==1: assert rsp_valid for the following cycle and return to IDLE.
- Effect on req_ready: low for exactly READ_LAT-1 cycles after read acceptance. A new request may be accepted in the rsp_valid cycle.
- Read data is captured at acceptance: the write-buffer entry if it is valid and its address matches, otherwise array[(addr-BASE)>>1].
- Read forwarding: a write accepted in the immediately preceding cycle is forwarded to the following read.
- Write accepted: load the write buffer (wb_valid, wb_addr, wb_data). wr_ack pulses the next cycle. req_ready stays high, so writes run at 1 per cycle.
- Write-buffer drain: the buffer writes into the array on the first edge after loading.
  - If a new write is accepted at that same edge, the old entry drains and the new entry loads simultaneously. There is no stall and no loss.
  - wb_valid clears when no new write arrives.
- Address check: fault when addr<BASE, addr>=BASE+2*DEPTH, or addr[0]==1. Address arithmetic is 17-bit, so the window end does not wrap.
  - A faulting request is still accepted and follows normal timing.
  - Faulting write: no buffer or array change; wr_ack and fault pulse together.
  - Faulting read: rsp_valid with rsp_rdata=16'h0000, and fault pulses with it.
  - fault_sticky sets on the cycle fault pulses.
- Reset values:
  - state=IDLE, cnt=0.
  - req_ready=1 from the first post-reset cycle.
  - rsp_valid=0, rsp_rdata=0, wr_ack=0, fault=0, fault_sticky=0, wb_valid=0.
- Reset mid-operation: a pending read is dropped (no rsp_valid), and a pending write-buffer entry is discarded without reaching the array. Array contents are not reset.
- req_wdata is ignored for reads; req_wr and req_wdata are ignored when req_valid=0.

Test Plan:
- Write 16'hBEEF to F010, then read F010 the next cycle (READ_LAT=2):
  - wr_ack pulses cycle 1.
  - req_ready=0 for one cycle.
  - rsp_valid with 16'hBEEF two cycles after read acceptance (forwarded from the write buffer).
- Push burst of 3 writes at F020/F022/F024 (1111/2222/3333), one per cycle, then reads of all three:
  - req_ready stays 1 during the burst.
  - Reads return 1111, 2222, 3333 in order.
  - No fault.
- READ_LAT=1, back-to-back reads at F000 and F002 preloaded 0xA5A5/0x5A5A:
  - rsp_valid on 2 consecutive cycles with those values.
  - req_ready never drops.
- Out-of-window and misaligned accesses:
  - Read at EFFE gives rsp_rdata=0 with fault=1 and fault_sticky=1.
  - Write at F011 gives wr_ack+fault, and a later read of F010 is unchanged.
  - Write at F200 (DEPTH=256) gives a fault.
- Reset mid-operation:
  - Assert reset in the RD_WAIT cycle: no rsp_valid follows, req_ready=1 the cycle after reset deasserts.
  - Write then immediate reset: a later read of that address returns the pre-write value.
